// File: rtl/rename_issue_queue.sv
// Out-of-order issue queue: renamed uops wait for pending source pregs, wake on
// completions, and the oldest ready entry is offered for issue each cycle.
module rename_issue_queue #(
    parameter int p_depth         = 8,
    parameter int p_num_phys_regs = 36,
    parameter int p_seq_num_bits  = 8,
    parameter int p_payload_bits  = 96,
    localparam int P  = $clog2(p_num_phys_regs),
    localparam int CW = $clog2(p_depth + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enq_val,
    output logic                      enq_rdy,
    input  logic [7:0]                enq_uop,
    input  logic [p_seq_num_bits-1:0] enq_seq_num,
    input  logic [1:0][P-1:0]         enq_src_preg,
    input  logic [1:0]                enq_src_pend,
    input  logic [p_payload_bits-1:0] enq_payload,
    input  logic                      cpl_val,
    input  logic                      cpl_wen,
    input  logic [P-1:0]              cpl_preg,
    output logic                      deq_val,
    input  logic                      deq_rdy,
    output logic [7:0]                deq_uop,
    output logic [p_seq_num_bits-1:0] deq_seq_num,
    output logic [1:0][P-1:0]         deq_src_preg,
    output logic [p_payload_bits-1:0] deq_payload,
    output logic [CW-1:0]             count
);

    localparam int IW = $clog2(p_depth);

    logic [p_depth-1:0]        valid_q;
    logic [CW-1:0]             count_q;
    logic [CW-1:0]             count_d;
    logic [7:0]                uop_q     [p_depth];
    logic [p_seq_num_bits-1:0] seq_q     [p_depth];
    logic [p_payload_bits-1:0] payload_q [p_depth];
    logic [1:0][P-1:0]         preg_q    [p_depth];
    logic [1:0]                pend_q    [p_depth];
    // older_q[i][j] set means entry j was enqueued before entry i.
    logic [p_depth-1:0]        older_q   [p_depth];

    logic [p_depth-1:0] ready;
    logic [p_depth-1:0] sel_oh;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      free_idx;
    logic [1:0]         enq_pend_d;
    logic               wake;
    logic               enq_xfer;
    logic               deq_xfer;

    assign wake     = cpl_val & cpl_wen;
    assign enq_rdy  = (count_q != CW'(p_depth));
    assign enq_xfer = enq_val & enq_rdy;
    assign deq_xfer = deq_val & deq_rdy;
    assign count    = count_q;
    assign count_d  = count_q + CW'(enq_xfer) - CW'(deq_xfer);

    // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        ready = '0;
        for (int i = 0; i < p_depth; i++) begin
            ready[i] = valid_q[i] & ~|pend_q[i];
        end
    end

    // The oldest ready entry is the one with no older ready entry.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < p_depth; i++) begin
            if (ready[i] && !(|(older_q[i] & ready))) begin
                sel_oh[i] = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = p_depth - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    always_comb begin
        enq_pend_d = enq_src_pend;
        for (int s = 0; s < 2; s++) begin
            if (wake && enq_src_preg[s] == cpl_preg) enq_pend_d[s] = 1'b0;
        end
    end

    assign deq_val      = (|ready) & ~rst;
    assign deq_uop      = uop_q[sel_idx];
    assign deq_seq_num  = seq_q[sel_idx];
    assign deq_src_preg = preg_q[sel_idx];
    assign deq_payload  = payload_q[sel_idx];

    // NOTE: only valid bits and the count are reset; entry contents are masked by valid_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < p_depth; i++) begin
                if (deq_xfer && sel_oh[i]) valid_q[i] <= 1'b0;
                for (int s = 0; s < 2; s++) begin
                    if (wake && preg_q[i][s] == cpl_preg) pend_q[i][s] <= 1'b0;
                end
                if (enq_xfer) older_q[i][free_idx] <= 1'b0;
            end
            if (enq_xfer) begin
                valid_q[free_idx]   <= 1'b1;
                uop_q[free_idx]     <= enq_uop;
                seq_q[free_idx]     <= enq_seq_num;
                payload_q[free_idx] <= enq_payload;
                preg_q[free_idx]    <= enq_src_preg;
                pend_q[free_idx]    <= enq_pend_d;
                older_q[free_idx]   <= valid_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rename_issue_queue.sv
// Bench for rename_issue_queue: directed scenarios plus a randomized run
// against an age-ordered list model of the queue.
module tb_rename_issue_queue;

    localparam int DEPTH = 8;
    localparam int P     = 6;

    typedef struct {
        logic [7:0]       uop;
        logic [7:0]       seq;
        logic [95:0]      pay;
        logic [1:0][P-1:0] preg;
        logic [1:0]       pend;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enq_val;
    logic             enq_rdy;
    logic [7:0]       enq_uop;
    logic [7:0]       enq_seq_num;
    logic [1:0][P-1:0] enq_src_preg;
    logic [1:0]       enq_src_pend;
    logic [95:0]      enq_payload;
    logic             cpl_val;
    logic             cpl_wen;
    logic [P-1:0]     cpl_preg;
    logic             deq_val;
    logic             deq_rdy;
    logic [7:0]       deq_uop;
    logic [7:0]       deq_seq_num;
    logic [1:0][P-1:0] deq_src_preg;
    logic [95:0]      deq_payload;
    logic [3:0]       count;

    int n_tests = 0;
    int n_fail  = 0;

    rename_issue_queue #(
        .p_depth(DEPTH), .p_num_phys_regs(36), .p_seq_num_bits(8), .p_payload_bits(96)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_uop(enq_uop), .enq_seq_num(enq_seq_num),
        .enq_src_preg(enq_src_preg), .enq_src_pend(enq_src_pend), .enq_payload(enq_payload),
        .cpl_val(cpl_val), .cpl_wen(cpl_wen), .cpl_preg(cpl_preg),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_uop(deq_uop), .deq_seq_num(deq_seq_num),
        .deq_src_preg(deq_src_preg), .deq_payload(deq_payload), .count(count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enq_val = 1'b0; enq_uop = '0; enq_seq_num = '0; enq_src_preg = '0;
        enq_src_pend = '0; enq_payload = '0;
        cpl_val = 1'b0; cpl_wen = 1'b0; cpl_preg = '0;
    endtask

    task automatic drive_enq(input logic [7:0] seq, input logic [P-1:0] p0, input logic pd0,
                             input logic [P-1:0] p1, input logic pd1, input logic [95:0] pay);
        enq_val = 1'b1; enq_seq_num = seq; enq_uop = seq + 8'h40;
        enq_src_preg[0] = p0; enq_src_pend[0] = pd0;
        enq_src_preg[1] = p1; enq_src_pend[1] = pd1;
        enq_payload = pay;
    endtask

    task automatic do_reset();
        idle_inputs();
        deq_rdy = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_enq_rdy got=%b exp=1", enq_rdy); end
        n_tests++; if (deq_val !== 1'b0) begin n_fail++; $display("FAIL reset_deq_val got=%b exp=0", deq_val); end
    endtask

    task automatic test_in_order();
        do_reset();
        deq_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_enq(8'(k), 6'd1, 1'b0, 6'd2, 1'b0, 96'(k));
            cyc();
            n_tests++; if (deq_val !== 1'b1 || deq_seq_num !== 8'(k)) begin
                n_fail++; $display("FAIL in_order_issue%0d got val=%b seq=%0d exp val=1 seq=%0d", k, deq_val, deq_seq_num, k);
            end
            n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL in_order_count%0d got=%0d exp=1", k, count); end
        end
        idle_inputs();
        cyc();
        n_tests++; if (count !== 4'd0 || deq_val !== 1'b0) begin
            n_fail++; $display("FAIL in_order_drain got count=%0d val=%b exp count=0 val=0", count, deq_val);
        end
    endtask

    task automatic test_wakeup();
        do_reset();
        deq_rdy = 1'b1;
        drive_enq(8'd5, 6'd12, 1'b1, 6'd3, 1'b0, 96'hA);
        cyc();
        n_tests++; if (deq_val !== 1'b0) begin n_fail++; $display("FAIL wake_a_blocked got val=%b exp=0", deq_val); end
        drive_enq(8'd6, 6'd4, 1'b0, 6'd5, 1'b0, 96'hB);
        cyc();
        n_tests++; if (deq_val !== 1'b1 || deq_seq_num !== 8'd6) begin
            n_fail++; $display("FAIL wake_b_first got val=%b seq=%0d exp val=1 seq=6", deq_val, deq_seq_num);
        end
        idle_inputs();
        cpl_val = 1'b1; cpl_wen = 1'b0; cpl_preg = 6'd12;
        cyc();
        n_tests++; if (deq_val !== 1'b0 || count !== 4'd1) begin
            n_fail++; $display("FAIL wake_wen0 got val=%b count=%0d exp val=0 count=1", deq_val, count);
        end
        cpl_wen = 1'b1;
        cyc();
        cpl_val = 1'b0;
        n_tests++; if (deq_val !== 1'b1 || deq_seq_num !== 8'd5 || deq_payload !== 96'hA) begin
            n_fail++; $display("FAIL wake_a_issue got val=%b seq=%0d exp val=1 seq=5", deq_val, deq_seq_num);
        end
        cyc();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL wake_drain got=%0d exp=0", count); end
    endtask

    task automatic test_bypass();
        do_reset();
        deq_rdy = 1'b1;
        drive_enq(8'd9, 6'd1, 1'b0, 6'd7, 1'b1, 96'h9);
        cpl_val = 1'b1; cpl_wen = 1'b1; cpl_preg = 6'd7;
        cyc();
        drive_enq(8'd10, 6'd1, 1'b0, 6'd7, 1'b1, 96'h10);
        cpl_preg = 6'd8;
        n_tests++; if (deq_val !== 1'b1 || deq_seq_num !== 8'd9) begin
            n_fail++; $display("FAIL bypass_hit got val=%b seq=%0d exp val=1 seq=9", deq_val, deq_seq_num);
        end
        cyc();
        idle_inputs();
        n_tests++; if (deq_val !== 1'b0 || count !== 4'd1) begin
            n_fail++; $display("FAIL bypass_miss got val=%b count=%0d exp val=0 count=1", deq_val, count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive_enq(8'(k), 6'(20 + k), 1'b1, 6'd0, 1'b0, 96'(k));
            cyc();
        end
        idle_inputs();
        n_tests++; if (count !== 4'd8 || enq_rdy !== 1'b0) begin
            n_fail++; $display("FAIL full_state got count=%0d rdy=%b exp count=8 rdy=0", count, enq_rdy);
        end
        cpl_val = 1'b1; cpl_wen = 1'b1; cpl_preg = 6'd20;
        cyc();
        cpl_val = 1'b0;
        n_tests++; if (deq_val !== 1'b1 || deq_seq_num !== 8'd0) begin
            n_fail++; $display("FAIL full_wake got val=%b seq=%0d exp val=1 seq=0", deq_val, deq_seq_num);
        end
        drive_enq(8'd99, 6'd0, 1'b0, 6'd0, 1'b0, 96'h99);
        deq_rdy = 1'b1;
        cyc();
        idle_inputs();
        deq_rdy = 1'b0;
        n_tests++; if (count !== 4'd7 || enq_rdy !== 1'b1 || deq_val !== 1'b0) begin
            n_fail++; $display("FAIL full_enq_refused got count=%0d rdy=%b val=%b exp count=7 rdy=1 val=0", count, enq_rdy, deq_val);
        end
    endtask

    task automatic test_hold();
        logic [95:0] hp;
        do_reset();
        hp = {$urandom, $urandom, $urandom};
        drive_enq(8'd33, 6'd2, 1'b0, 6'd3, 1'b0, hp);
        cyc();
        drive_enq(8'd34, 6'd2, 1'b0, 6'd3, 1'b0, ~hp);
        cyc();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (deq_val !== 1'b1 || deq_seq_num !== 8'd33 || deq_payload !== hp) begin
                n_fail++; $display("FAIL hold_cycle%0d got val=%b seq=%0d exp val=1 seq=33", k, deq_val, deq_seq_num);
            end
            cyc();
        end
        deq_rdy = 1'b1;
        cyc();
        deq_rdy = 1'b0;
        n_tests++; if (count !== 4'd1 || deq_seq_num !== 8'd34 || deq_payload !== ~hp) begin
            n_fail++; $display("FAIL hold_one_issue got count=%0d seq=%0d exp count=1 seq=34", count, deq_seq_num);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_enq(8'(k), 6'd1, 1'b0, 6'd1, 1'b0, 96'(k));
            cyc();
        end
        n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL rst_mid_pre got=%0d exp=5", count); end
        rst = 1'b1; deq_rdy = 1'b1;
        drive_enq(8'd50, 6'd1, 1'b0, 6'd1, 1'b0, 96'd0);
        cyc();
        rst = 1'b0;
        idle_inputs();
        deq_rdy = 1'b0;
        n_tests++; if (count !== 4'd0 || deq_val !== 1'b0 || enq_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_post got count=%0d val=%b rdy=%b exp 0/0/1", count, deq_val, enq_rdy);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   exp_idx;
        logic enq_x;
        logic deq_x;
        logic [7:0] next_seq = 8'd0;
        do_reset();
        for (int c = 0; c < 10000 && n_fail < 50; c++) begin
            exp_idx = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].pend == 2'b00) begin exp_idx = i; break; end
            end
            n_tests++; if (count !== 4'(q.size()) || enq_rdy !== (q.size() != DEPTH)) begin
                n_fail++; $display("FAIL rnd_occupancy c=%0d got count=%0d rdy=%b exp count=%0d", c, count, enq_rdy, q.size());
            end
            n_tests++; if (deq_val !== (exp_idx >= 0)) begin
                n_fail++; $display("FAIL rnd_deq_val c=%0d got=%b exp=%b", c, deq_val, exp_idx >= 0);
            end
            if (exp_idx >= 0) begin
                n_tests++;
                if (deq_seq_num !== q[exp_idx].seq || deq_uop !== q[exp_idx].uop ||
                    deq_payload !== q[exp_idx].pay || deq_src_preg !== q[exp_idx].preg) begin
                    n_fail++; $display("FAIL rnd_deq_data c=%0d got seq=%0d exp seq=%0d", c, deq_seq_num, q[exp_idx].seq);
                end
            end
            enq_val = ($urandom_range(99) < 60);
            enq_seq_num = next_seq;
            enq_uop = 8'($urandom);
            enq_payload = {$urandom, $urandom, $urandom};
            enq_src_preg[0] = 6'($urandom_range(5));
            enq_src_preg[1] = 6'($urandom_range(5));
            enq_src_pend = 2'($urandom);
            cpl_val = ($urandom_range(99) < 50);
            cpl_wen = ($urandom_range(99) < 75);
            cpl_preg = 6'($urandom_range(5));
            deq_rdy = ($urandom_range(99) < 70);
            enq_x = enq_val && (q.size() < DEPTH);
            deq_x = (exp_idx >= 0) && deq_rdy;
            @(posedge clk);
            if (deq_x) q.delete(exp_idx);
            if (cpl_val && cpl_wen) begin
                for (int i = 0; i < q.size(); i++) begin
                    for (int s = 0; s < 2; s++) if (q[i].preg[s] == cpl_preg) q[i].pend[s] = 1'b0;
                end
            end
            if (enq_x) begin
                e.uop = enq_uop; e.seq = enq_seq_num; e.pay = enq_payload;
                e.preg = enq_src_preg; e.pend = enq_src_pend;
                for (int s = 0; s < 2; s++) begin
                    if (cpl_val && cpl_wen && e.preg[s] == cpl_preg) e.pend[s] = 1'b0;
                end
                q.push_back(e);
                next_seq++;
            end
            @(negedge clk);
        end
        idle_inputs();
        deq_rdy = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        deq_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_in_order();
        test_wakeup();
        test_bypass();
        test_full();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
